// File: rtl/barret_1973_arbiter.sv
// Round-robin arbiter sharing one combinational mod-1973 Barrett reducer across NREQ requesters.
// Optional build macro BARRET_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.

module barret_for_1973 (
  input  logic [20:0] din_a,
  output logic [10:0] dout_r
);
  // MU = floor(2^32 / 1973); for 21-bit inputs the quotient estimate is low by at most one
  localparam logic [21:0] MU = 22'd2176871;
  localparam logic [21:0] MOD22 = 22'd1973;
  localparam logic [11:0] MOD12 = 12'd1973;

  logic [10:0] q;
  logic [11:0] r_pre;

  always_comb begin
    q      = 11'(({22'd0, din_a} * {21'd0, MU}) >> 32);
    r_pre  = 12'({1'b0, din_a} - ({11'd0, q} * MOD22));
    dout_r = (r_pre >= MOD12) ? 11'(r_pre - MOD12) : r_pre[10:0];
  end
endmodule

module barret_1973_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int W_IN  = 21,
  parameter int W_OUT = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*W_IN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [W_OUT-1:0]     rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready
);
  localparam int unsigned NREQ_U = NREQ;

  logic              a_vld;
  logic [W_IN-1:0]   a_data;
  logic [IDW-1:0]    a_id;
  logic [W_OUT-1:0]  red_out;

  logic              stall_b;
  logic              adv_a;
  logic              a_free;
  logic              hs;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gid;
  logic              found;
  int unsigned       base;
  int unsigned       idx;
  logic [IDW-1:0]    idx_s;

  barret_for_1973 u_red (
    .din_a  (a_data),
    .dout_r (red_out)
  );

  always_comb begin
    stall_b = rsp_valid & ~rsp_ready;
    adv_a   = a_vld & ~stall_b;
    a_free  = ~a_vld | adv_a;
  end

`ifdef BARRET_ARB_FIXED_PRIO_EN
  always_comb base = 0;
`else
  logic [IDW-1:0] rr_ptr;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  always_comb base = 32'(rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (gid == LAST_ID) ? '0 : gid + 1'b1;
    end
  end
`endif

  // Rotating search: offset k from base, wrapped without a modulo operator
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = base + k;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      idx_s = IDW'(idx);
      if (!found && req_valid[idx_s]) begin
        found        = 1'b1;
        grant[idx_s] = 1'b1;
        gid          = idx_s;
      end
    end
    req_ready = a_free ? grant : '0;
    hs        = a_free & found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld  <= 1'b0;
      a_data <= '0;
      a_id   <= '0;
    end else if (hs) begin
      a_vld  <= 1'b1;
      a_data <= req_data[gid*W_IN +: W_IN];
      a_id   <= gid;
    end else if (adv_a) begin
      a_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (adv_a) begin
      rsp_valid <= 1'b1;
      rsp_data  <= red_out;
      rsp_id    <= a_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_barret_1973_arbiter.sv
// Randomized self-checking bench for barret_1973_arbiter against a slot-level model using plain % arithmetic.
// Honours BARRET_ARB_FIXED_PRIO_EN for grant-order expectations.

module tb_barret_1973_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [83:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [10:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b0;

  barret_1973_arbiter #(.NREQ(4), .IDW(2), .W_IN(21), .W_OUT(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [20:0] src [4][$];
  bit rsp_rand = 0;
  bit gate_rand = 0;

  bit          ma_v = 0, mb_v = 0;
  int          ma_id = 0, mb_id = 0, mptr = 0;
  logic [20:0] ma_op = '0, mb_op = '0;
  int          sb_id [$];
  logic [20:0] sb_op [$];

  int acc_log [$];
  int acc_cyc [$];
  int rsp_dlog [$];
  int rsp_ilog [$];
  int rsp_cyc [$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Reference model and per-cycle compare
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      ma_v = 0; mb_v = 0; mptr = 0;
      sb_id.delete(); sb_op.delete();
    end else begin
      bit stall, adv, afree;
      int g;
      int unsigned expg;
      stall = mb_v && !rsp_ready;
      adv   = ma_v && !stall;
      afree = !ma_v || adv;
      g     = pick(req_valid, mptr);
      expg  = (afree && g >= 0) ? (32'd1 << g) : 0;
      chk("req_ready", req_ready, expg);
      chk("rsp_valid", rsp_valid, mb_v);
      if (mb_v) begin
        chk("rsp_data", rsp_data, mb_op % 1973);
        chk("rsp_id", rsp_id, mb_id);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_id.size() == 0) note_fail("sb_underflow");
        else begin
          int eid;
          logic [20:0] eop;
          eid = sb_id.pop_front();
          eop = sb_op.pop_front();
          chk("order_data", rsp_data, eop % 1973);
          chk("order_id", rsp_id, eid);
        end
        rsp_dlog.push_back(rsp_data);
        rsp_ilog.push_back(rsp_id);
        rsp_cyc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) begin
          acc_log.push_back(i);
          acc_cyc.push_back(cyc);
        end
      if (adv) begin
        mb_v = 1; mb_op = ma_op; mb_id = ma_id;
      end else if (rsp_ready) begin
        mb_v = 0;
      end
      if (afree && g >= 0) begin
        ma_v = 1; ma_op = req_data[g*21 +: 21]; ma_id = g;
        sb_id.push_back(g); sb_op.push_back(ma_op);
`ifndef BARRET_ARB_FIXED_PRIO_EN
        mptr = (g + 1) % 4;
`endif
      end else if (adv) begin
        ma_v = 0;
      end
    end
  end

  // Requester driver: pops an operand once its handshake is seen
  always begin
    logic [3:0] hs_s;
    bit rs;
    @(negedge clk);
    hs_s = req_valid & req_ready;
    rs = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (rs && hs_s[i] && src[i].size() > 0) void'(src[i].pop_front());
    if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      bit gt;
      gt = gate_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      req_valid[i] = (src[i].size() > 0) && gt;
      req_data[i*21 +: 21] = (src[i].size() > 0) ? src[i][0] : 21'd0;
    end
  end

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete();
    rsp_dlog.delete(); rsp_ilog.delete(); rsp_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) src[i].delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() > 0 ||
            sb_id.size() > 0 || ma_v || mb_v) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) note_fail(nm);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_acc(input int cnt, input string nm);
    int n;
    n = 0;
    while (acc_log.size() < cnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) note_fail(nm);
  endtask

  initial begin
    logic [20:0] ops [10];
    int exp_t1 [5];

    // Test 1: single requester back to back
    do_reset();
    rsp_ready = 1'b1;
    src[0].push_back(21'd0);
    src[0].push_back(21'd1972);
    src[0].push_back(21'd1973);
    src[0].push_back(21'd4000);
    src[0].push_back(21'd2097151);
    drain("t1_drain");
    exp_t1 = '{0, 1972, 0, 54, 1825};
    chk("t1_count", rsp_dlog.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t1_data", rsp_dlog[k], exp_t1[k]);
      chk("t1_id", rsp_ilog[k], 0);
      chk("t1_spacing", rsp_cyc[k] - rsp_cyc[0], k);
    end
    chk("t1_latency", rsp_cyc[0] - acc_cyc[0], 2);

    // Test 2: all four requesters contending
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src[i].push_back(21'(1973 * i + i));
      src[i].push_back(21'(1973 * i + i));
    end
    drain("t2_drain");
    chk("t2_count", acc_log.size(), 8);
`ifdef BARRET_ARB_FIXED_PRIO_EN
    chk("t2_grant0", acc_log[0], 0);
    chk("t2_grant1", acc_log[1], 0);
    chk("t2_grant2", acc_log[2], 1);
    chk("t2_rsp_id0", rsp_ilog[0], 0);
    chk("t2_rsp_data0", rsp_dlog[0], 0);
`else
    for (int k = 0; k < 5; k++) chk("t2_grant", acc_log[k], k % 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_rsp_id", rsp_ilog[k], k);
      chk("t2_rsp_data", rsp_dlog[k], k);
    end
`endif

    // Test 3: backpressure with both stages full
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ops[k] = 21'($urandom_range(0, 2097151));
      src[2].push_back(ops[k]);
    end
    wait_acc(2, "t3_accept");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t3_ready_low", req_ready, 0);
      chk("t3_rsp_valid_hold", rsp_valid, 1);
      chk("t3_rsp_data_hold", rsp_data, ops[0] % 1973);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    drain("t3_drain");
    chk("t3_count", rsp_dlog.size(), 10);
    for (int k = 0; k < 10; k++) chk("t3_data", rsp_dlog[k], ops[k] % 1973);

    // Test 4: requesters 1 and 3 with pointer at 2
    do_reset();
    rsp_ready = 1'b1;
    src[1].push_back(21'd5000);
    drain("t4a_drain");
    clear_logs();
    src[1].push_back(21'd1974);
    src[3].push_back(21'd3950);
    drain("t4b_drain");
`ifdef BARRET_ARB_FIXED_PRIO_EN
    chk("t4_first", acc_log[0], 1);
    chk("t4_second", acc_log[1], 3);
`else
    chk("t4_first", acc_log[0], 3);
    chk("t4_second", acc_log[1], 1);
`endif
    chk("t4_rsp0", rsp_dlog[0], (acc_log[0] == 3) ? 4 : 1);

    // Test 5: reset with both stages full
    do_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src[0].push_back(21'(k + 100));
      src[2].push_back(21'(k + 200));
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    chk("t5_full_before", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid_drop", rsp_valid, 0);
    for (int i = 0; i < 4; i++) src[i].delete();
    src[1].push_back(21'd1980);
    src[1].push_back(21'd7);
    src[3].push_back(21'd3946);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
    rst_n = 1'b1;
    drain("t5_drain");
    chk("t5_first_grant", acc_log[0], 1);
    chk("t5_rsp_count", rsp_dlog.size(), 3);

    // Test 6: randomized sweep
    do_reset();
    rsp_rand = 1;
    gate_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (src[i].size() < 3 && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 5))
            0: src[i].push_back(21'd2097151 - 21'($urandom_range(0, 3)));
            1: src[i].push_back(21'(1973 * $urandom_range(0, 1062)));
            2: src[i].push_back(21'(1973 * $urandom_range(1, 1062) - 1));
            default: src[i].push_back(21'($urandom_range(0, 2097151)));
          endcase
        end
    end
    rsp_rand = 0;
    gate_rand = 0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    drain("t6_drain");
    chk("t6_sb_empty", sb_id.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
